// File: rtl/fb_fill_engine.sv
// rtl/fb_fill_engine.sv - rectangle-fill DMA writing a constant colour into the ARGB8888 frame buffer
// MMIO-programmed; one outstanding AXI4 INCR write burst at a time, row by row, never crossing 4 KB.

module fb_fill_engine #(
   parameter int FB_WIDTH      = 640,
   parameter int FB_HEIGHT     = 480,
   parameter int MAX_BURST_LEN = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        io_bus_s_rd_en,
   input  logic        io_bus_s_wr_en,
   input  logic        io_bus_s_cs,
   input  logic [31:0] io_bus_s_address,
   input  logic [31:0] io_bus_s_wr_data,
   output logic [31:0] io_bus_s_rd_data,
   output logic        done_irq,
   output logic [31:0] axi_awaddr,
   output logic [7:0]  axi_awlen,
   output logic [2:0]  axi_awsize,
   output logic [1:0]  axi_awburst,
   output logic        axi_awvalid,
   input  logic        axi_awready,
   output logic [31:0] axi_wdata,
   output logic [3:0]  axi_wstrb,
   output logic        axi_wlast,
   output logic        axi_wvalid,
   input  logic        axi_wready,
   input  logic [1:0]  axi_bresp,
   input  logic        axi_bvalid,
   output logic        axi_bready
);

   localparam logic [15:0] FBW   = 16'(FB_WIDTH);
   localparam logic [15:0] FBH   = 16'(FB_HEIGHT);
   localparam logic [15:0] MAXB  = 16'(MAX_BURST_LEN);
   localparam logic [31:0] FBW32 = 32'(FB_WIDTH);
   localparam logic [31:0] PITCH = 32'(FB_WIDTH * 4);

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      ISSUE_AW,
      SEND_W,
      WAIT_B
   } state_t;

   state_t state, state_nxt;

   logic [31:0] base_r, colour_r;
   logic [9:0]  x_r, y_r, w_r, h_r;

   logic [31:0] fill_colour, cur_addr, row_addr;
   logic [15:0] row_w, row_rem, rows_left;
   logic [15:0] burst_beats, beat_cnt;
   logic        done_sticky, err_sticky;

   logic        mmio_wr, mmio_rd, ctrl_wr, start_req, clear_req;
   logic [7:0]  reg_sel;
   logic        unused_addr_bits;

   logic [15:0] x_ext, y_ext, w_ext, h_ext, w_room, h_room, w_eff, h_eff;
   logic        start_clipped;
   logic [31:0] start_addr;
   logic [15:0] page_rem, beats_calc;
   logic        rect_empty, row_last_burst, rect_last_burst;

   assign reg_sel   = io_bus_s_address[7:0];
   assign mmio_wr   = io_bus_s_cs & io_bus_s_wr_en;
   assign mmio_rd   = io_bus_s_cs & io_bus_s_rd_en;
   assign ctrl_wr   = mmio_wr && (reg_sel == 8'h10);
   assign start_req = ctrl_wr && io_bus_s_wr_data[0] && (state == IDLE);
   assign clear_req = ctrl_wr && io_bus_s_wr_data[1];
   assign unused_addr_bits = ^io_bus_s_address[31:8];

   // Clip the programmed rectangle against the frame buffer at start time.
   always_comb begin
      x_ext         = {6'b0, x_r};
      y_ext         = {6'b0, y_r};
      w_ext         = {6'b0, w_r};
      h_ext         = {6'b0, h_r};
      start_clipped = (x_ext >= FBW) || (y_ext >= FBH);
      w_room        = FBW - x_ext;
      h_room        = FBH - y_ext;
      w_eff         = start_clipped ? 16'd0 : ((w_ext < w_room) ? w_ext : w_room);
      h_eff         = start_clipped ? 16'd0 : ((h_ext < h_room) ? h_ext : h_room);
      start_addr    = base_r + ((32'(y_r) * FBW32 + 32'(x_r)) << 2);
   end

   // Burst length limited by row remainder, max burst and distance to the next 4 KB page.
   always_comb begin
      page_rem   = 16'd1024 - {6'b0, cur_addr[11:2]};
      beats_calc = row_rem;
      if (MAXB < beats_calc) beats_calc = MAXB;
      if (page_rem < beats_calc) beats_calc = page_rem;
   end

   assign rect_empty      = (row_rem == 16'd0) || (rows_left == 16'd0);
   assign row_last_burst  = (row_rem == burst_beats);
   assign rect_last_burst = row_last_burst && (rows_left == 16'd1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      axi_awvalid = 1'b0;
      axi_wvalid  = 1'b0;
      axi_wlast   = 1'b0;
      axi_bready  = 1'b0;
      case (state)
         IDLE: begin
            if (start_req) state_nxt = SETUP;
         end
         SETUP: begin
            state_nxt = rect_empty ? IDLE : ISSUE_AW;
         end
         ISSUE_AW: begin
            axi_awvalid = 1'b1;
            if (axi_awready) state_nxt = SEND_W;
         end
         SEND_W: begin
            axi_wvalid = 1'b1;
            axi_wlast  = (beat_cnt == burst_beats - 16'd1);
            if (axi_wready && axi_wlast) state_nxt = WAIT_B;
         end
         WAIT_B: begin
            axi_bready = 1'b1;
            if (axi_bvalid) state_nxt = rect_last_burst ? IDLE : SETUP;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign axi_awaddr  = cur_addr;
   assign axi_awlen   = 8'(burst_beats - 16'd1);
   assign axi_awsize  = 3'b010;
   assign axi_awburst = 2'b01;
   assign axi_wdata   = fill_colour;
   assign axi_wstrb   = 4'hF;
   assign done_irq    = done_sticky;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         base_r   <= '0;
         colour_r <= '0;
         x_r      <= '0;
         y_r      <= '0;
         w_r      <= '0;
         h_r      <= '0;
      end else if (mmio_wr) begin
         case (reg_sel)
            8'h00: base_r   <= {io_bus_s_wr_data[31:2], 2'b00};
            8'h04: begin
               x_r <= io_bus_s_wr_data[9:0];
               y_r <= io_bus_s_wr_data[25:16];
            end
            8'h08: begin
               w_r <= io_bus_s_wr_data[9:0];
               h_r <= io_bus_s_wr_data[25:16];
            end
            8'h0C: colour_r <= io_bus_s_wr_data;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fill_colour <= '0;
         cur_addr    <= '0;
         row_addr    <= '0;
         row_w       <= '0;
         row_rem     <= '0;
         rows_left   <= '0;
         burst_beats <= '0;
         beat_cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start_req) begin
                  fill_colour <= colour_r;
                  cur_addr    <= start_addr;
                  row_addr    <= start_addr;
                  row_w       <= w_eff;
                  row_rem     <= w_eff;
                  rows_left   <= h_eff;
               end
            end
            SETUP: begin
               burst_beats <= beats_calc;
               beat_cnt    <= '0;
            end
            SEND_W: begin
               if (axi_wready) beat_cnt <= beat_cnt + 16'd1;
            end
            WAIT_B: begin
               if (axi_bvalid) begin
                  if (row_last_burst) begin
                     rows_left <= rows_left - 16'd1;
                     row_addr  <= row_addr + PITCH;
                     cur_addr  <= row_addr + PITCH;
                     row_rem   <= row_w;
                  end else begin
                     cur_addr <= cur_addr + (32'(burst_beats) << 2);
                     row_rem  <= row_rem - burst_beats;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // A completion in the same cycle as a clear still leaves the flag set.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         done_sticky <= 1'b0;
         err_sticky  <= 1'b0;
      end else begin
         if (clear_req) begin
            done_sticky <= 1'b0;
            err_sticky  <= 1'b0;
         end
         if ((state == SETUP && rect_empty) ||
             (state == WAIT_B && axi_bvalid && rect_last_burst))
            done_sticky <= 1'b1;
         if (state == WAIT_B && axi_bvalid && axi_bresp != 2'b00)
            err_sticky <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         io_bus_s_rd_data <= '0;
      end else if (mmio_rd) begin
         case (reg_sel)
            8'h00:   io_bus_s_rd_data <= base_r;
            8'h04:   io_bus_s_rd_data <= {6'b0, y_r, 6'b0, x_r};
            8'h08:   io_bus_s_rd_data <= {6'b0, h_r, 6'b0, w_r};
            8'h0C:   io_bus_s_rd_data <= colour_r;
            8'h10:   io_bus_s_rd_data <= {29'b0, err_sticky, done_sticky, state != IDLE};
            default: io_bus_s_rd_data <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_fb_fill_engine.sv
// tb/tb_fb_fill_engine.sv - self-checking bench for fb_fill_engine
// AXI slave with stall/error injection; expected bursts come from a loop-level frame buffer model.

module tb_fb_fill_engine;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rd_en = 1'b0, wr_en = 1'b0, cs = 1'b0;
   logic [31:0] address = '0, wr_data = '0;
   logic [31:0] rd_data;
   logic        done_irq;
   logic [31:0] axi_awaddr;
   logic [7:0]  axi_awlen;
   logic [2:0]  axi_awsize;
   logic [1:0]  axi_awburst;
   logic        axi_awvalid;
   logic        axi_awready = 1'b0;
   logic [31:0] axi_wdata;
   logic [3:0]  axi_wstrb;
   logic        axi_wlast, axi_wvalid;
   logic        axi_wready = 1'b0;
   logic [1:0]  axi_bresp = 2'b00;
   logic        axi_bvalid = 1'b0;
   logic        axi_bready;

   fb_fill_engine dut (
      .clk(clk), .rst(rst_n),
      .io_bus_s_rd_en(rd_en), .io_bus_s_wr_en(wr_en), .io_bus_s_cs(cs),
      .io_bus_s_address(address), .io_bus_s_wr_data(wr_data), .io_bus_s_rd_data(rd_data),
      .done_irq(done_irq),
      .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
      .axi_awburst(axi_awburst), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
      .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
      .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
      .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] base;
      int          x, y, w, h;
      logic [31:0] colour;
      int          aw_delay;
      bit          wrand;
      int          bad_b;
      bit          busy_restart;
      int          exp_bursts;
      logic [31:0] exp_addr0;
      int          exp_len0;
      bit          exp_err;
   } vec_t;

   int checks = 0;
   int errors = 0;

   // slave controls and observations
   int          aw_delay_g = 0;
   bit          wrand_g = 1'b0;
   int          bad_b_g = -1;
   logic [31:0] colour_g = '0;
   int          burst_idx = 0, total_beats = 0;
   int          unstable = 0, overlap = 0, data_err = 0, timeouts = 0;
   logic [31:0] got_a[$];
   int          got_l[$];

   // model expectations
   logic [31:0] exp_a[$];
   int          exp_l[$];
   int          exp_beats;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Frame-buffer view: clip the rectangle, walk each row, split at 32 beats and 4 KB pages.
   task automatic model(input vec_t v);
      longint we, he, a, rem, pg, b;
      exp_a.delete();
      exp_l.delete();
      exp_beats = 0;
      if (v.x >= 640 || v.y >= 480) return;
      we = (v.w < 640 - v.x) ? v.w : 640 - v.x;
      he = (v.h < 480 - v.y) ? v.h : 480 - v.y;
      for (longint r = 0; r < he; r++) begin
         a   = ((v.base & 32'hFFFF_FFFC) + ((v.y + r) * 640 + v.x) * 4) % 64'h1_0000_0000;
         rem = we;
         while (rem > 0) begin
            pg = (4096 - (a % 4096)) / 4;
            b  = rem;
            if (b > 32) b = 32;
            if (b > pg) b = pg;
            exp_a.push_back(32'(a));
            exp_l.push_back(int'(b - 1));
            exp_beats += int'(b);
            a   = (a + b * 4) % 64'h1_0000_0000;
            rem = rem - b;
         end
      end
   endtask

   task automatic slave_idle();
      axi_awready = 1'b0;
      axi_wready  = 1'b0;
      axi_bvalid  = 1'b0;
      axi_bresp   = 2'b00;
   endtask

   task automatic slave_txn();
      logic [31:0] a;
      logic [7:0]  l;
      int          beats, guard;
      bit          wr;
      @(negedge clk);
      if (!rst_n || !axi_awvalid) return;
      a = axi_awaddr;
      l = axi_awlen;
      if (axi_wvalid) overlap++;
      if (axi_awsize != 3'b010 || axi_awburst != 2'b01) data_err++;
      for (int d = 0; d < aw_delay_g; d++) begin
         @(negedge clk);
         if (!rst_n) begin slave_idle(); return; end
         if (!axi_awvalid || axi_awaddr != a || axi_awlen != l) unstable++;
         if (axi_wvalid) overlap++;
      end
      axi_awready = 1'b1;
      @(negedge clk);
      axi_awready = 1'b0;
      if (!rst_n) begin slave_idle(); return; end
      got_a.push_back(a);
      got_l.push_back(int'(l));
      beats = 0;
      guard = 0;
      while (beats <= int'(l)) begin
         if (guard++ > 3000) begin timeouts++; slave_idle(); return; end
         wr = wrand_g ? 1'($urandom_range(0, 1)) : 1'b1;
         axi_wready = wr;
         if (axi_awvalid) overlap++;
         if (wr && axi_wvalid) begin
            if (axi_wdata != colour_g || axi_wstrb != 4'hF) data_err++;
            if (axi_wlast != (beats == int'(l))) data_err++;
            beats++;
            total_beats++;
         end
         @(negedge clk);
         if (!rst_n) begin slave_idle(); return; end
      end
      axi_wready = 1'b0;
      if (axi_wvalid) data_err++;
      axi_bresp  = (burst_idx == bad_b_g) ? 2'b10 : 2'b00;
      axi_bvalid = 1'b1;
      guard = 0;
      while (!axi_bready && guard < 100) begin
         guard++;
         @(negedge clk);
         if (!rst_n) begin slave_idle(); return; end
      end
      if (guard >= 100) timeouts++;
      @(negedge clk);
      axi_bvalid = 1'b0;
      axi_bresp  = 2'b00;
      burst_idx++;
   endtask

   initial forever slave_txn();

   task automatic mmio_write(input logic [7:0] a, input logic [31:0] d);
      cs = 1'b1; wr_en = 1'b1; address = {24'h0, a}; wr_data = d;
      @(negedge clk);
      cs = 1'b0; wr_en = 1'b0;
   endtask

   task automatic mmio_read(input logic [7:0] a, output logic [31:0] d);
      cs = 1'b1; rd_en = 1'b1; address = {24'h0, a};
      @(negedge clk);
      cs = 1'b0; rd_en = 1'b0;
      d = rd_data;
   endtask

   task automatic program_regs(input vec_t v);
      logic [9:0] xv, yv, wv, hv;
      xv = 10'(v.x); yv = 10'(v.y); wv = 10'(v.w); hv = 10'(v.h);
      mmio_write(8'h00, v.base);
      mmio_write(8'h04, {6'b0, yv, 6'b0, xv});
      mmio_write(8'h08, {6'b0, hv, 6'b0, wv});
      mmio_write(8'h0C, v.colour);
      mmio_write(8'h10, 32'h2);
   endtask

   task automatic run_case(input vec_t v, input string tag);
      logic [31:0] st;
      bit          exp_err_m;
      int          n;
      model(v);
      aw_delay_g = v.aw_delay; wrand_g = v.wrand; bad_b_g = v.bad_b; colour_g = v.colour;
      burst_idx = 0; total_beats = 0; unstable = 0; overlap = 0; data_err = 0; timeouts = 0;
      got_a.delete();
      got_l.delete();
      exp_err_m = (v.bad_b >= 0) && (v.bad_b < exp_a.size());
      program_regs(v);
      mmio_write(8'h10, 32'h1);
      if (v.busy_restart) begin
         mmio_write(8'h00, 32'hDEAD_0000);
         mmio_write(8'h10, 32'h1);
      end
      @(negedge clk);
      mmio_read(8'h10, st);
      chk({tag, " status_after_start"}, st, (exp_a.size() == 0) ? 32'h2 : 32'h1);
      for (int i = 0; i < 20000 && !done_irq; i++) @(negedge clk);
      chk({tag, " done_irq"}, done_irq, 1'b1);
      repeat (3) @(negedge clk);
      mmio_read(8'h10, st);
      chk({tag, " status_final"}, st, {29'b0, exp_err_m, 2'b10});
      chk({tag, " burst_count"}, got_a.size(), exp_a.size());
      n = (got_a.size() < exp_a.size()) ? got_a.size() : exp_a.size();
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s awaddr[%0d]", tag, i), got_a[i], exp_a[i]);
         chk($sformatf("%s awlen[%0d]", tag, i), got_l[i], exp_l[i]);
      end
      chk({tag, " beats"}, total_beats, exp_beats);
      chk({tag, " protocol"}, {unstable, overlap, data_err, timeouts}, 128'h0);
      if (v.exp_bursts >= 0) begin
         chk({tag, " table_bursts"}, got_a.size(), v.exp_bursts);
         chk({tag, " table_err"}, st[2], v.exp_err);
         if (v.exp_bursts > 0 && got_a.size() > 0) begin
            chk({tag, " table_addr0"}, got_a[0], v.exp_addr0);
            chk({tag, " table_len0"}, got_l[0], v.exp_len0);
         end
      end
   endtask

   vec_t tbl[7];

   initial begin
      logic [31:0] st;
      vec_t        v;
      int          g;

      tbl[0] = '{32'h1000_0000, 0, 0, 640, 1, 32'hFF11_2233, 0, 1'b0, -1, 1'b1, 20, 32'h1000_0000, 31, 1'b0};
      tbl[1] = '{32'h0000_0F00, 56, 0, 40, 1, 32'h8000_00FF, 0, 1'b0, -1, 1'b0, 2, 32'h0000_0FE0, 7, 1'b0};
      tbl[2] = '{32'h2000_0000, 630, 0, 20, 2, 32'h1234_5678, 1, 1'b0, -1, 1'b0, 2, 32'h2000_09D8, 9, 1'b0};
      tbl[3] = '{32'h2000_0000, 10, 10, 0, 5, 32'hAAAA_5555, 0, 1'b0, -1, 1'b0, 0, 32'h0, 0, 1'b0};
      tbl[4] = '{32'h2000_0000, 700, 10, 20, 5, 32'hAAAA_5555, 0, 1'b0, -1, 1'b0, 0, 32'h0, 0, 1'b0};
      tbl[5] = '{32'h3000_0003, 10, 3, 50, 2, 32'hCAFE_F00D, 5, 1'b1, 1, 1'b0, 4, 32'h3000_1E28, 31, 1'b1};
      tbl[6] = '{32'h0000_0000, 600, 478, 100, 5, 32'h0BAD_BEEF, 2, 1'b1, -1, 1'b0, 4, 32'h0012_B560, 31, 1'b0};

      repeat (2) @(negedge clk);
      chk("reset awvalid", axi_awvalid, 1'b0);
      chk("reset wvalid", axi_wvalid, 1'b0);
      chk("reset wlast", axi_wlast, 1'b0);
      chk("reset bready", axi_bready, 1'b0);
      chk("reset done_irq", done_irq, 1'b0);
      chk("reset rd_data", rd_data, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      mmio_read(8'h10, st);
      chk("reset status", st, 32'h0);
      mmio_write(8'h04, 32'hFFFF_FFFF);
      mmio_read(8'h04, st);
      chk("xy readback", st, 32'h03FF_03FF);
      mmio_read(8'h14, st);
      chk("unmapped read", st, 32'h0);

      for (int i = 0; i < 7; i++) run_case(tbl[i], $sformatf("vec%0d", i));

      for (int i = 0; i < 6; i++) begin
         v.base = $urandom; v.x = $urandom_range(0, 700); v.y = $urandom_range(0, 490);
         v.w = $urandom_range(0, 100); v.h = $urandom_range(0, 4); v.colour = $urandom;
         v.aw_delay = $urandom_range(0, 3); v.wrand = 1'b1;
         v.bad_b = $urandom_range(0, 1) ? int'($urandom_range(0, 3)) : -1;
         v.busy_restart = 1'b0; v.exp_bursts = -1; v.exp_addr0 = '0; v.exp_len0 = 0; v.exp_err = 1'b0;
         run_case(v, $sformatf("rnd%0d", i));
      end

      // asynchronous reset in the middle of a write burst
      aw_delay_g = 0; wrand_g = 1'b0; bad_b_g = -1; colour_g = tbl[0].colour;
      program_regs(tbl[0]);
      mmio_write(8'h10, 32'h1);
      g = 0;
      while (!axi_wvalid && g < 200) begin g++; @(negedge clk); end
      chk("rst_mid wvalid_seen", axi_wvalid, 1'b1);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid awvalid", axi_awvalid, 1'b0);
      chk("rst_mid wvalid", axi_wvalid, 1'b0);
      chk("rst_mid wlast", axi_wlast, 1'b0);
      chk("rst_mid bready", axi_bready, 1'b0);
      chk("rst_mid done_irq", done_irq, 1'b0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      mmio_read(8'h10, st);
      chk("rst_mid status", st, 32'h0);
      run_case(tbl[2], "post_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
